// File: rtl/hack_pkg.sv
// hack_pkg: constants shared by the Hack-style memory blocks.
//   WORD_W       data word width of the datapath
//   RAM8_ADDR_W  word-select width inside one ram8 bank
//   NUM_BANKS    number of ram8 banks that make up ram64
//   WORD_ZERO    value every word takes on reset
//   BANK_MSB/LSB position of the bank index inside a ram64 address
package hack_pkg;

  localparam int WORD_W      = 16;
  localparam int RAM8_ADDR_W = 3;
  localparam int RAM8_DEPTH  = 2 ** RAM8_ADDR_W;
  localparam int NUM_BANKS   = 8;
  localparam int BANK_MSB    = 5;
  localparam int BANK_LSB    = 3;

  localparam logic [WORD_W-1:0] WORD_ZERO = '0;

endpackage : hack_pkg

// File: rtl/ram64_ram8.sv
// ram8: 8 x WIDTH register file, one bank of ram64.
//   clk      rising-edge clock for writes
//   rst_n    asynchronous active-low reset, clears all eight words
//   in       write data
//   load     write enable, active high
//   address  word select within the bank
//   out      contents of the addressed word, combinational
module ram8
  import hack_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       in,
  input  logic                   load,
  input  logic [RAM8_ADDR_W-1:0] address,
  output logic [WIDTH-1:0]       out
);

  logic [WIDTH-1:0] mem [RAM8_DEPTH];

  // Reset clears the whole bank without a clock and dominates load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RAM8_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (load) begin
      mem[address] <= in;
    end
  end

  // No bypass from in: a same-address write becomes visible only after the edge.
  assign out = mem[address];

endmodule : ram8

// File: rtl/ram64.sv
// ram64: 64 x WIDTH random-access memory built from eight ram8 banks.
//   clk      rising-edge clock for writes
//   rst_n    asynchronous active-low reset, clears all 64 words
//   in       write data
//   load     write enable, active high
//   address  word select; [5:3] picks the bank, [2:0] the word in the bank
//   out      contents of the addressed word, combinational
module ram64
  import hack_pkg::*;
#(
  parameter int WIDTH  = WORD_W,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  in,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  output logic [WIDTH-1:0]  out
);

  logic [BANK_MSB-BANK_LSB:0] bank;
  logic [RAM8_ADDR_W-1:0]     word;
  logic [NUM_BANKS-1:0]       bank_load;
  logic [WIDTH-1:0]           bank_out [NUM_BANKS];

  assign bank = address[BANK_MSB:BANK_LSB];
  assign word = address[RAM8_ADDR_W-1:0];

  // One-hot 3:8 decode gated by load, so at most one bank writes per edge.
  always_comb begin
    bank_load = '0;
    if (load) begin
      bank_load[bank] = 1'b1;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    ram8 #(
      .WIDTH (WIDTH)
    ) u_ram8 (
      .clk     (clk),
      .rst_n   (rst_n),
      .in      (in),
      .load    (bank_load[b]),
      .address (word),
      .out     (bank_out[b])
    );
  end

  // 8:1 read mux over the bank outputs.
  assign out = bank_out[bank];

endmodule : ram64

// File: tb/tb_ram64.sv
module tb_ram64;

  logic        clk;
  logic        rst_n;
  logic [15:0] in;
  logic        load;
  logic [5:0]  address;
  logic [15:0] out;

  int n_checks;
  int n_fail;

  ram64 #(
    .WIDTH  (16),
    .ADDR_W (6)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in      (in),
    .load    (load),
    .address (address),
    .out     (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present a write on the falling edge, commit it on the next rising edge.
  task automatic write_word(input logic [5:0] a, input logic [15:0] d);
    @(negedge clk);
    address = a;
    in      = d;
    load    = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [5:0] a, input logic [15:0] exp);
    address = a;
    #1;
    check(tag, out, exp);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    load     = 1'b0;
    in       = 16'h0000;
    address  = 6'd0;

    #2;
    check("reset_initial", out, 16'h0000);
    #10;
    rst_n = 1'b1;

    // Reset sweep after pre-writing addr 5
    write_word(6'd5, 16'hFFFF);
    read_check("prewrite_5", 6'd5, 16'hFFFF);
    @(negedge clk);
    rst_n = 1'b0;
    for (int k = 0; k < 64; k++) begin
      read_check($sformatf("reset_sweep_%0d", k), 6'(k), 16'h0000);
    end
    #1;
    rst_n = 1'b1;
    read_check("after_reset_5", 6'd5, 16'h0000);

    // Single write
    write_word(6'd10, 16'hA5A5);
    read_check("single_10", 6'd10, 16'hA5A5);
    read_check("neighbour_9", 6'd9, 16'h0000);
    read_check("neighbour_11", 6'd11, 16'h0000);

    // Bank isolation: back-to-back writes of each index
    for (int k = 0; k < 64; k++) begin
      write_word(6'(k), {10'h000, 6'(k)});
    end
    for (int k = 0; k < 64; k++) begin
      read_check($sformatf("isolation_%0d", k), 6'(k), {10'h000, 6'(k)});
    end

    // Load gating
    @(negedge clk);
    load    = 1'b0;
    address = 6'd20;
    in      = 16'h1234;
    repeat (3) @(posedge clk);
    #1;
    check("load_gating_20", out, 16'h0014);
    read_check("load_gating_19", 6'd19, 16'h0013);

    // Consecutive same-address writes: last wins
    write_word(6'd7, 16'hAAAA);
    write_word(6'd7, 16'h5555);
    read_check("last_wins_7", 6'd7, 16'h5555);
    read_check("last_wins_8", 6'd8, 16'h0008);

    // Read-during-write at addr 33
    @(negedge clk);
    address = 6'd33;
    in      = 16'hBEEF;
    load    = 1'b1;
    #1;
    check("rdw_before", out, 16'h0021);
    @(posedge clk);
    #1;
    check("rdw_after", out, 16'hBEEF);
    load = 1'b0;
    read_check("rdw_other_32", 6'd32, 16'h0020);

    // Async reset mid-write at addr 40, then a write on the next edge
    @(negedge clk);
    address = 6'd40;
    in      = 16'h7777;
    load    = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    check("midwrite_reset_40", out, 16'h0000);
    #1;
    rst_n = 1'b1;
    in    = 16'h0001;
    #1;
    check("post_release_40", out, 16'h0000);
    @(posedge clk);
    #1;
    check("first_write_40", out, 16'h0001);
    load = 1'b0;
    read_check("post_reset_33", 6'd33, 16'h0000);
    read_check("post_reset_63", 6'd63, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_ram64
